// File: rtl/tvp5147_config_sequencer.sv
// Power-up / re-init sequencer for the TVP5147M1: walks a {sub_addr, data} table and
// pushes each entry through the I2C master, with optional read-back verify and retries.
module tvp5147_config_sequencer #(
  parameter int unsigned NUM_REGS       = 32,
  parameter logic [7:0]  SLAVE_ADDR     = 8'hB8,
  parameter int unsigned STARTUP_DELAY  = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 65_535,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          VERIFY         = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        i2c_start,
  output logic        i2c_rw,
  output logic [7:0]  i2c_slave_addr,
  output logic [7:0]  i2c_sub_addr,
  output logic [7:0]  i2c_data_in,
  input  logic [7:0]  i2c_data_out,
  input  logic        i2c_busy,
  input  logic        i2c_ack_error,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  err_index
);

  localparam logic [7:0]  LAST_IDX  = 8'(NUM_REGS - 1);
  localparam logic [31:0] DLY_LAST  = 32'((STARTUP_DELAY  == 0) ? 0 : STARTUP_DELAY  - 1);
  localparam logic [31:0] TMO_LAST  = 32'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, WAIT_PWR, FETCH, LATCH, REQ, WAIT_LO, CHECK, NEXT, DONE, FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  sub_q, sub_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  eidx_q, eidx_d;
  logic        phase_q, phase_d;   // 0: write pass, 1: read-back pass
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        fail_att;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_PWR;
      cnt_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      sub_q   <= '0;
      dat_q   <= '0;
      eidx_q  <= '0;
      phase_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      sub_q   <= sub_d;
      dat_q   <= dat_d;
      eidx_q  <= eidx_d;
      phase_q <= phase_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // cnt_q serves both the startup delay and the per-phase timeouts; it is
  // cleared on entry to every phase so each wait gets its own full budget.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    sub_d    = sub_q;
    dat_d    = dat_q;
    eidx_d   = eidx_q;
    phase_d  = phase_q;
    start_d  = start_q;
    done_d   = done_q;
    err_d    = err_q;
    fail_att = 1'b0;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (cfg_start) begin
          state_d = WAIT_PWR;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          eidx_d  = '0;
          idx_d   = '0;
          retry_d = '0;
          phase_d = 1'b0;
        end
      end
      WAIT_PWR: begin
        if (cnt_q >= DLY_LAST) begin
          state_d = FETCH;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 32'd1;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        sub_d   = rom_data[15:8];
        dat_d   = rom_data[7:0];
        phase_d = 1'b0;
        cnt_d   = '0;
        state_d = REQ;
      end
      REQ: begin
        // Only raise start once the master is idle, then hold it until busy is seen.
        if (start_q && i2c_busy) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else if (cnt_q >= TMO_LAST) begin
          fail_att = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (!i2c_busy) start_d = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!i2c_busy)              state_d  = CHECK;
        else if (cnt_q >= TMO_LAST) fail_att = 1'b1;
        else                        cnt_d    = cnt_q + 32'd1;
      end
      CHECK: begin
        if (!phase_q) begin
          if (i2c_ack_error)  fail_att = 1'b1;
          else if (VERIFY) begin
            phase_d = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end else state_d = NEXT;
        end else if (!i2c_ack_error && (i2c_data_out == dat_q)) state_d = NEXT;
        else fail_att = 1'b1;
      end
      NEXT: begin
        retry_d = '0;
        phase_d = 1'b0;
        if (idx_q >= LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail_att) begin
      start_d = 1'b0;
      cnt_d   = '0;
      phase_d = 1'b0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 8'd1;
        state_d = REQ;
      end else begin
        eidx_d  = idx_q;
        err_d   = 1'b1;
        state_d = FAIL;
      end
    end
  end

  assign busy_d = !(state_d inside {IDLE, DONE, FAIL});

  assign rom_addr       = idx_q;
  assign i2c_start      = start_q;
  assign i2c_rw         = phase_q;
  assign i2c_slave_addr = SLAVE_ADDR;
  assign i2c_sub_addr   = sub_q;
  assign i2c_data_in    = dat_q;
  assign cfg_busy       = busy_q;
  assign cfg_done       = done_q;
  assign cfg_error      = err_q;
  assign err_index      = eidx_q;

endmodule

// File: tb/tb_tvp5147_config_sequencer.sv
// Directed bench: 3-entry table, behavioural I2C master/slave with NACK, bad-read
// and dead-bus modes, plus restart and asynchronous reset scenarios.
module tb_tvp5147_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        i2c_start, i2c_rw;
  logic [7:0]  i2c_slave_addr, i2c_sub_addr, i2c_data_in;
  logic [7:0]  m_dout = '0;
  logic        m_busy = 1'b0;
  logic        m_ack = 1'b0;
  logic        cfg_busy, cfg_done, cfg_error;
  logic [7:0]  err_index;

  tvp5147_config_sequencer #(
    .NUM_REGS(3), .SLAVE_ADDR(8'hB8), .STARTUP_DELAY(8),
    .TIMEOUT_CYCLES(40), .MAX_RETRIES(3), .VERIFY(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_slave_addr(i2c_slave_addr),
    .i2c_sub_addr(i2c_sub_addr), .i2c_data_in(i2c_data_in),
    .i2c_data_out(m_dout), .i2c_busy(m_busy), .i2c_ack_error(m_ack),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_sub [0:2] = '{8'h02, 8'h03, 8'h0F};
  logic [7:0] exp_dat [0:2] = '{8'h11, 8'h22, 8'h5A};

  always @(posedge clk)
    rom_data <= (rom_addr < 8'd3) ? {exp_sub[rom_addr], exp_dat[rom_addr]} : 16'h0000;

  // Transaction log and slave register file, owned by the master model.
  logic       lrw  [0:127];
  logic [7:0] lsub [0:127];
  logic [7:0] ldat [0:127];
  logic [7:0] mem  [0:255];
  int         ntx = 0;
  int         base = 0;
  int         bcnt = 0;
  int         nk;
  logic       nack_en = 1'b0, bad_rd = 1'b0, no_busy = 1'b0;
  logic       do_nack;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      bcnt   <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) m_busy <= 1'b0;
    end else if (i2c_start && !m_busy && !no_busy) begin
      nk = 0;
      for (int k = base; k < ntx; k++)
        if (!lrw[k] && lsub[k] == 8'h03) nk++;
      m_busy    <= 1'b1;
      bcnt      <= 4;
      lrw[ntx]  <= i2c_rw;
      lsub[ntx] <= i2c_sub_addr;
      ldat[ntx] <= i2c_data_in;
      ntx       <= ntx + 1;
      if (!i2c_rw) begin
        do_nack = nack_en && (i2c_sub_addr == 8'h03) && (nk < 2);
        m_ack <= do_nack;
        if (!do_nack) mem[i2c_sub_addr] <= i2c_data_in;
      end else begin
        m_ack  <= 1'b0;
        m_dout <= (bad_rd && i2c_sub_addr == 8'h0F) ? 8'h00 : mem[i2c_sub_addr];
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(cfg_done || cfg_error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, 32'(cfg_done | cfg_error), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk) cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
  endtask

  task automatic chk_clean_run(input string tag);
    chk({tag, "_ntx"}, 32'(ntx - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_rw"},  32'(lrw[base+i]),  32'(i % 2));
      chk({tag, "_sub"}, 32'(lsub[base+i]), 32'(exp_sub[i/2]));
      if (!lrw[base+i]) chk({tag, "_wdat"}, 32'(ldat[base+i]), 32'(exp_dat[i/2]));
    end
    chk({tag, "_done"},  32'(cfg_done),  32'd1);
    chk({tag, "_error"}, 32'(cfg_error), 32'd0);
    chk({tag, "_busy"},  32'(cfg_busy),  32'd0);
  endtask

  initial begin
    int n, cnt;
    #1;
    chk("rst_start",  32'(i2c_start), 32'd0);
    chk("rst_busy",   32'(cfg_busy),  32'd0);
    chk("rst_done",   32'(cfg_done),  32'd0);
    chk("rst_error",  32'(cfg_error), 32'd0);
    chk("rst_eidx",   32'(err_index), 32'd0);
    chk("rst_romadr", 32'(rom_addr),  32'd0);
    chk("rst_slave",  32'(i2c_slave_addr), 32'hB8);
    #20 rst_n = 1'b1;

    // Run 1: auto-start after reset, slave always ACKs.
    repeat (3) @(negedge clk);
    chk("r1_busy_early", 32'(cfg_busy), 32'd1);
    wait_end("r1");
    chk_clean_run("r1");

    // Run 2: restart from DONE, with a cfg_start pulse mid-sequence.
    base = ntx;
    pulse_start();
    chk("r2_done_clr", 32'(cfg_done), 32'd0);
    repeat (30) @(negedge clk);
    pulse_start();
    chk("r2_busy_mid", 32'(cfg_busy), 32'd1);
    wait_end("r2");
    chk_clean_run("r2");

    // Run 3: entry 1 write NACKed twice, then ACKed.
    base = ntx;
    nack_en = 1'b1;
    pulse_start();
    wait_end("r3");
    nack_en = 1'b0;
    cnt = 0;
    for (int k = base; k < ntx; k++) if (!lrw[k] && lsub[k] == 8'h03) cnt++;
    chk("r3_ntx",   32'(ntx - base), 32'd8);
    chk("r3_wr03",  32'(cnt), 32'd3);
    chk("r3_done",  32'(cfg_done),  32'd1);
    chk("r3_error", 32'(cfg_error), 32'd0);

    // Run 4: read-back of entry 2 always wrong.
    base = ntx;
    bad_rd = 1'b1;
    pulse_start();
    wait_end("r4");
    bad_rd = 1'b0;
    chk("r4_ntx",   32'(ntx - base), 32'd12);
    chk("r4_error", 32'(cfg_error), 32'd1);
    chk("r4_eidx",  32'(err_index), 32'd2);
    chk("r4_done",  32'(cfg_done),  32'd0);
    chk("r4_busy",  32'(cfg_busy),  32'd0);

    // Run 5: master never raises busy.
    base = ntx;
    no_busy = 1'b1;
    pulse_start();
    chk("r5_err_clr", 32'(cfg_error), 32'd0);
    wait_end("r5");
    no_busy = 1'b0;
    chk("r5_ntx",   32'(ntx - base), 32'd0);
    chk("r5_error", 32'(cfg_error), 32'd1);
    chk("r5_eidx",  32'(err_index), 32'd0);
    chk("r5_start", 32'(i2c_start), 32'd0);
    chk("r5_done",  32'(cfg_done),  32'd0);

    // Run 6: asynchronous reset while waiting on entry 1's write.
    pulse_start();
    n = 0;
    while (!(m_busy && !i2c_start && i2c_sub_addr == 8'h03 && !i2c_rw) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("r6_reach_wait", 32'(i2c_sub_addr), 32'h03);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("r6_rst_busy",   32'(cfg_busy),     32'd0);
    chk("r6_rst_romadr", 32'(rom_addr),     32'd0);
    chk("r6_rst_sub",    32'(i2c_sub_addr), 32'd0);
    chk("r6_rst_data",   32'(i2c_data_in),  32'd0);
    chk("r6_rst_start",  32'(i2c_start),    32'd0);
    chk("r6_rst_slave",  32'(i2c_slave_addr), 32'hB8);
    repeat (2) @(negedge clk);
    base = ntx;
    rst_n = 1'b1;
    wait_end("r6");
    chk_clean_run("r6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
